// File: rtl/vga_sprite_render_if.sv
// vga_sprite_render_if: pixel-stream, sprite-ROM and video-output bundle for vga_sprite_render.
//   master: timing generator + sprite ROM side (drives coordinates, syncs, player position, rom_data)
//   slave : render stage (drives rom_addr, rgb, hsync, vsync, frame_tick)
interface vga_sprite_render_if #(
    parameter int HWIDTH   = 12,
    parameter int VWIDTH   = 12,
    parameter int SPR_LOG2 = 5
);
    logic [HWIDTH-1:0]     hdata;
    logic [VWIDTH-1:0]     vdata;
    logic                  valid;
    logic                  hsync_in;
    logic                  vsync_in;
    logic [HWIDTH-1:0]     player_x;
    logic [VWIDTH-1:0]     player_y;
    logic [2*SPR_LOG2:0]   rom_addr;
    logic [11:0]           rom_data;
    logic [11:0]           rgb;
    logic                  hsync;
    logic                  vsync;
    logic                  frame_tick;

    modport master (
        output hdata, vdata, valid, hsync_in, vsync_in, player_x, player_y, rom_data,
        input  rom_addr, rgb, hsync, vsync, frame_tick
    );

    modport slave (
        input  hdata, vdata, valid, hsync_in, vsync_in, player_x, player_y, rom_data,
        output rom_addr, rgb, hsync, vsync, frame_tick
    );
endinterface

// File: rtl/vga_sprite_render.sv
// vga_sprite_render: 3-stage render pipeline drawing lane background and an animated sprite.
//   clk   : pixel clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : vga_sprite_render_if.slave (coordinates/syncs/player position in, ROM port, RGB/syncs/frame_tick out)
// Optional feature: define SPRITE_KEY_EN to make sprite pixels equal to KEY_RGB transparent.
module vga_sprite_render #(
    parameter int         HWIDTH    = 12,
    parameter int         VWIDTH    = 12,
    parameter int         VSIZE     = 480,
    parameter int         SPR_LOG2  = 5,
    parameter int         ANIM_DIV  = 8,
    parameter int         LANE_X0   = 160,
    parameter int         LANE_X1   = 320,
    parameter int         LANE_X2   = 480,
    parameter int         EDGE_W    = 4,
    parameter logic [11:0] BG_RGB   = 12'h642,
    parameter logic [11:0] EDGE_RGB = 12'hFFF,
    parameter logic [11:0] KEY_RGB  = 12'hF0F,
    parameter logic       SYNC_IDLE = 1'b0
) (
    input logic                clk,
    input logic                rst_n,
    vga_sprite_render_if.slave bus
);
    localparam int SPR = 1 << SPR_LOG2;
    localparam int CW  = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
    localparam int XW  = HWIDTH + 1;
    localparam int YW  = VWIDTH + 1;

    logic [HWIDTH-1:0]   r_px;
    logic [VWIDTH-1:0]   r_py;
    logic [CW-1:0]       r_frame_cnt;
    logic                r_anim;
    logic                r_frame_tick;
    logic [2*SPR_LOG2:0] r_rom_addr;
    logic                r_valid1, r_hit1, r_edge1, r_hs1, r_vs1;
    logic                r_valid2, r_hit2, r_edge2, r_hs2, r_vs2;
    logic [11:0]         r_rgb;
    logic                r_hs3, r_vs3;

    logic [XW-1:0]       w_hx;
    logic [YW-1:0]       w_vy;
    logic                w_latch;
    logic                w_hit;
    logic                w_edge;
    logic [SPR_LOG2-1:0] w_dx;
    logic [SPR_LOG2-1:0] w_dy;
    logic                w_opaque;
    logic [11:0]         w_pixel;

    // One extra bit so a sprite near the right/bottom limit clips instead of wrapping to column/line 0.
    assign w_hx    = {1'b0, bus.hdata};
    assign w_vy    = {1'b0, bus.vdata};
    assign w_latch = (bus.hdata == '0) && (bus.vdata == VWIDTH'(VSIZE));
    assign w_hit   = (w_hx >= {1'b0, r_px}) && (w_hx < {1'b0, r_px} + XW'(SPR)) &&
                     (w_vy >= {1'b0, r_py}) && (w_vy < {1'b0, r_py} + YW'(SPR));
    assign w_dx    = SPR_LOG2'(bus.hdata - r_px);
    assign w_dy    = SPR_LOG2'(bus.vdata - r_py);
    assign w_edge  = ((w_hx >= XW'(LANE_X0)) && (w_hx < XW'(LANE_X0 + EDGE_W))) ||
                     ((w_hx >= XW'(LANE_X1)) && (w_hx < XW'(LANE_X1 + EDGE_W))) ||
                     ((w_hx >= XW'(LANE_X2)) && (w_hx < XW'(LANE_X2 + EDGE_W)));

`ifdef SPRITE_KEY_EN
    assign w_opaque = bus.rom_data != KEY_RGB;
`else
    assign w_opaque = 1'b1;
`endif

    assign w_pixel = !r_valid2            ? 12'h000 :
                     (r_hit2 && w_opaque) ? bus.rom_data :
                     r_edge2              ? EDGE_RGB : BG_RGB;

    // Position and animation phase are sampled only at the latch point, so they hold through the visible frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_px         <= '0;
            r_py         <= '0;
            r_frame_cnt  <= '0;
            r_anim       <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_latch;
            if (w_latch) begin
                r_px        <= bus.player_x;
                r_py        <= bus.player_y;
                r_frame_cnt <= (r_frame_cnt == CW'(ANIM_DIV - 1)) ? '0 : r_frame_cnt + 1'b1;
                r_anim      <= (r_frame_cnt == CW'(ANIM_DIV - 1)) ? ~r_anim : r_anim;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_addr <= '0;
            r_valid1   <= 1'b0;
            r_hit1     <= 1'b0;
            r_edge1    <= 1'b0;
            r_hs1      <= SYNC_IDLE;
            r_vs1      <= SYNC_IDLE;
            r_valid2   <= 1'b0;
            r_hit2     <= 1'b0;
            r_edge2    <= 1'b0;
            r_hs2      <= SYNC_IDLE;
            r_vs2      <= SYNC_IDLE;
            r_rgb      <= '0;
            r_hs3      <= SYNC_IDLE;
            r_vs3      <= SYNC_IDLE;
        end else begin
            r_rom_addr <= w_hit ? {r_anim, w_dy, w_dx} : '0;
            r_valid1   <= bus.valid;
            r_hit1     <= w_hit;
            r_edge1    <= w_edge;
            r_hs1      <= bus.hsync_in;
            r_vs1      <= bus.vsync_in;
            r_valid2   <= r_valid1;
            r_hit2     <= r_hit1;
            r_edge2    <= r_edge1;
            r_hs2      <= r_hs1;
            r_vs2      <= r_vs1;
            r_rgb      <= w_pixel;
            r_hs3      <= r_hs2;
            r_vs3      <= r_vs2;
        end
    end

    assign bus.rom_addr   = r_rom_addr;
    assign bus.rgb        = r_rgb;
    assign bus.hsync      = r_hs3;
    assign bus.vsync      = r_vs3;
    assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_vga_sprite_render.sv
// tb_vga_sprite_render: randomized self-checking bench against a pixel-level reference model.
module tb_vga_sprite_render;
    localparam int VSIZE     = 480;
    localparam int SPR       = 32;
    localparam int ANIM_DIV  = 8;
    localparam bit SYNC_IDLE = 1'b0;
`ifdef SPRITE_KEY_EN
    localparam logic [11:0] KEYED_PIX = 12'h642;
`else
    localparam logic [11:0] KEYED_PIX = 12'hF0F;
`endif

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        int          h;
        int          v;
    } exp_t;

    typedef struct {
        int v;
        int h0;
        int h1;
        bit inv;
    } seg_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    vga_sprite_render_if #(.HWIDTH(12), .VWIDTH(12), .SPR_LOG2(5)) bus();
    vga_sprite_render dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [11:0] rom_mem [0:2047];
    always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

    exp_t q[$];
    int m_px, m_py, m_nlatch;
    int pl_x, pl_y;
    int tests, fails;
    logic [11:0] got_rgb, exp_rgb;
    logic got_hs, got_vs, exp_hs, exp_vs, got_tick, exp_tick;
    logic [10:0] got_addr, exp_addr;
    int exp_h, exp_v;

    function automatic int anim();
        return (m_nlatch / ANIM_DIV) % 2;
    endfunction

    function automatic bit in_box(int h, int v);
        return h >= m_px && h < m_px + SPR && v >= m_py && v < m_py + SPR;
    endfunction

    function automatic int m_addr(int h, int v);
        return anim() * 1024 + (v - m_py) * 32 + (h - m_px);
    endfunction

    function automatic logic [11:0] m_pix(int h, int v, bit val);
        logic [11:0] w;
        bit lane;
        if (!val) return 12'h000;
        lane = (h >= 160 && h < 164) || (h >= 320 && h < 324) || (h >= 480 && h < 484);
        if (in_box(h, v)) begin
            w = rom_mem[m_addr(h, v)];
`ifdef SPRITE_KEY_EN
            if (w != 12'hF0F) return w;
`else
            return w;
`endif
        end
        return lane ? 12'hFFF : 12'h642;
    endfunction

    task automatic model_reset();
        exp_t e;
        m_px = 0; m_py = 0; m_nlatch = 0;
        q.delete();
        e.rgb = 12'h000; e.hs = SYNC_IDLE; e.vs = SYNC_IDLE; e.h = -1; e.v = -1;
        q.push_back(e);
        q.push_back(e);
    endtask

    task automatic step(input int h, input int v, input bit val, input bit hs, input bit vs);
        exp_t e;
        bus.hdata = 12'(h); bus.vdata = 12'(v); bus.valid = val;
        bus.hsync_in = hs; bus.vsync_in = vs;
        bus.player_x = 12'(pl_x); bus.player_y = 12'(pl_y);
        e.h = h; e.v = v; e.hs = hs; e.vs = vs;
        e.rgb = m_pix(h, v, val);
        exp_addr = in_box(h, v) ? 11'(m_addr(h, v)) : 11'd0;
        exp_tick = (h == 0 && v == VSIZE);
        if (exp_tick) begin m_px = pl_x; m_py = pl_y; m_nlatch++; end
        q.push_back(e);
        @(posedge clk); #1;
        got_rgb = bus.rgb; got_hs = bus.hsync; got_vs = bus.vsync;
        got_addr = bus.rom_addr; got_tick = bus.frame_tick;
        e = q.pop_front();
        exp_rgb = e.rgb; exp_hs = e.hs; exp_vs = e.vs; exp_h = e.h; exp_v = e.v;
    endtask

    task automatic set_rom(input int mode);
        step(700, 600, 0, 0, 0);
        step(700, 600, 0, 0, 0);
        for (int i = 0; i < 2048; i++)
            rom_mem[i] = mode == 0 ? 12'h0F0 : mode == 1 ? 12'hF0F :
                         ($urandom_range(3) == 0 ? 12'hF0F : 12'($urandom));
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2048; i++) rom_mem[i] = 12'($urandom);
        bus.valid = 1'b1; bus.player_x = 12'd0; bus.player_y = 12'd0;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.hdata = i == 2 ? 12'd0 : 12'(5 + i); bus.vdata = i == 2 ? 12'd480 : 12'd10;
            bus.hsync_in = ~SYNC_IDLE; bus.vsync_in = ~SYNC_IDLE;
            @(posedge clk); #1;
            tests++;
            if ({bus.rgb, bus.hsync, bus.vsync, bus.rom_addr, bus.frame_tick} !== {12'h000, SYNC_IDLE, SYNC_IDLE, 11'd0, 1'b0}) begin
                fails++;
                $display("FAIL reset_held: got rgb=%h hs=%b vs=%b addr=%h tick=%b exp rgb=000 hs/vs=%b addr=0 tick=0",
                         bus.rgb, bus.hsync, bus.vsync, bus.rom_addr, bus.frame_tick, SYNC_IDLE);
            end
        end
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        pl_x = 0; pl_y = 0;
        for (int i = 0; i < 16; i++) begin
            step(300 + i, 100, 1, i >= 12 ? ~SYNC_IDLE : 1'($urandom), 1'($urandom));
            tests++;
            if ({got_rgb, got_hs, got_vs} !== {exp_rgb, exp_hs, exp_vs}) begin
                fails++;
                $display("FAIL reset_release pix(%0d,%0d): got rgb=%h hs=%b vs=%b exp rgb=%h hs=%b vs=%b",
                         exp_h, exp_v, got_rgb, got_hs, got_vs, exp_rgb, exp_hs, exp_vs);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.rgb, bus.hsync, bus.vsync, bus.rom_addr, bus.frame_tick} !== {12'h000, SYNC_IDLE, SYNC_IDLE, 11'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_async: got rgb=%h hs=%b vs=%b addr=%h tick=%b exp all cleared",
                     bus.rgb, bus.hsync, bus.vsync, bus.rom_addr, bus.frame_tick);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            step(316 + i, 100, 1, 1'($urandom), 1'($urandom));
            tests++;
            if ({got_rgb, got_hs, got_vs} !== {exp_rgb, exp_hs, exp_vs}) begin
                fails++;
                $display("FAIL reset_midline pix(%0d,%0d): got rgb=%h hs=%b vs=%b exp rgb=%h hs=%b vs=%b",
                         exp_h, exp_v, got_rgb, got_hs, got_vs, exp_rgb, exp_hs, exp_vs);
            end
        end
    endtask

    task automatic run_segs(input string name, input seg_t segs[$]);
        foreach (segs[s])
            for (int h = segs[s].h0; h <= segs[s].h1; h++) begin
                step(h, segs[s].v, !segs[s].inv && h < 640 && segs[s].v < VSIZE, 1'($urandom), 1'($urandom));
                tests++;
                if ({got_rgb, got_hs, got_vs} !== {exp_rgb, exp_hs, exp_vs}) begin
                    fails++;
                    $display("FAIL %s pix(%0d,%0d): got rgb=%h hs=%b vs=%b exp rgb=%h hs=%b vs=%b",
                             name, exp_h, exp_v, got_rgb, got_hs, got_vs, exp_rgb, exp_hs, exp_vs);
                end
                tests++;
                if ({got_addr, got_tick} !== {exp_addr, exp_tick}) begin
                    fails++;
                    $display("FAIL %s addr(%0d,%0d): got addr=%h tick=%b exp addr=%h tick=%b",
                             name, h, segs[s].v, got_addr, got_tick, exp_addr, exp_tick);
                end
            end
    endtask

    task automatic test_sprite();
        set_rom(0);
        pl_x = 100; pl_y = 200;
        step(0, VSIZE, 0, 0, 0);
        run_segs("sprite", '{'{200, 90, 140, 0}, '{215, 95, 135, 0}, '{231, 95, 135, 0}, '{232, 95, 135, 0}});
    endtask

    task automatic test_clip();
        set_rom(2);
        pl_x = 630; pl_y = 10;
        step(0, VSIZE, 0, 0, 0);
        run_segs("clip_right", '{'{10, 620, 661, 0}, '{11, 0, 8, 0}});
        pl_x = 700;
        step(0, VSIZE, 0, 0, 0);
        run_segs("clip_off", '{'{10, 600, 760, 0}, '{25, 690, 740, 0}});
        pl_x = 4090; pl_y = 470;
        step(0, VSIZE, 0, 0, 0);
        run_segs("clip_wrap", '{'{470, 4080, 4095, 0}, '{471, 0, 8, 0}, '{479, 4085, 4095, 0}, '{480, 4088, 4095, 0}, '{501, 4088, 4095, 0}, '{502, 4088, 4095, 0}});
    endtask

    task automatic test_edges();
        pl_x = 700; pl_y = 600;
        step(0, VSIZE, 0, 0, 0);
        run_segs("edges", '{'{300, 156, 170, 0}, '{300, 316, 326, 0}, '{300, 476, 486, 0}, '{300, 636, 645, 0}, '{300, 158, 166, 1}});
    endtask

    task automatic test_key();
        int seen;
        set_rom(1);
        pl_x = 150; pl_y = 300;
        step(0, VSIZE, 0, 0, 0);
        seen = 0;
        for (int h = 145; h <= 185; h++) begin
            step(h, 305, 1, 0, 0);
            tests++;
            if (got_rgb !== exp_rgb) begin
                fails++;
                $display("FAIL key pix(%0d,%0d): got rgb=%h exp rgb=%h", exp_h, exp_v, got_rgb, exp_rgb);
            end
            if (exp_h == 170) begin
                seen++;
                tests++;
                if (got_rgb !== KEYED_PIX) begin
                    fails++;
                    $display("FAIL key_col170: got rgb=%h exp rgb=%h", got_rgb, KEYED_PIX);
                end
            end
        end
        tests++;
        if (seen != 1) begin
            fails++;
            $display("FAIL key_seen: got %0d exp 1", seen);
        end
    endtask

    task automatic test_latch();
        int ticks;
        set_rom(2);
        pl_x = 100; pl_y = 200;
        step(0, VSIZE, 0, 0, 0);
        run_segs("latch_before", '{'{205, 95, 140, 0}});
        pl_x = 300;
        run_segs("latch_hold", '{'{210, 95, 140, 0}, '{210, 295, 340, 0}});
        step(0, VSIZE, 0, 0, 0);
        run_segs("latch_after", '{'{210, 95, 140, 0}, '{210, 295, 340, 0}});
        ticks = 0;
        for (int f = 0; f < 20; f++) begin
            step(0, VSIZE, 0, 0, 0);
            ticks += int'(got_tick);
            step(310, 205, 1, 0, 0);
            ticks += int'(got_tick);
            tests++;
            if (got_addr !== exp_addr || got_addr[10] !== 1'(anim())) begin
                fails++;
                $display("FAIL anim frame %0d: got addr=%h exp addr=%h anim=%0d", m_nlatch, got_addr, exp_addr, anim());
            end
        end
        tests++;
        if (ticks != 20) begin
            fails++;
            $display("FAIL frame_tick_count: got %0d exp 20", ticks);
        end
    endtask

    task automatic test_random();
        int h, v;
        bit val;
        set_rom(2);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(39) == 0) begin
                pl_x = $urandom_range(660); pl_y = $urandom_range(500);
                h = 0; v = VSIZE; val = 0;
            end else if ($urandom_range(1) == 0) begin
                h = m_px + $urandom_range(39) - 4; v = m_py + $urandom_range(39) - 4;
                h = h < 0 ? 0 : h; v = v < 0 ? 0 : v;
                val = $urandom_range(9) == 0 ? 1'($urandom) : (h < 640 && v < VSIZE);
            end else begin
                h = $urandom_range(799); v = $urandom_range(524);
                val = $urandom_range(9) == 0 ? 1'($urandom) : (h < 640 && v < VSIZE);
            end
            step(h, v, val, 1'($urandom), 1'($urandom));
            tests++;
            if ({got_rgb, got_hs, got_vs} !== {exp_rgb, exp_hs, exp_vs}) begin
                fails++;
                $display("FAIL random pix(%0d,%0d): got rgb=%h hs=%b vs=%b exp rgb=%h hs=%b vs=%b",
                         exp_h, exp_v, got_rgb, got_hs, got_vs, exp_rgb, exp_hs, exp_vs);
            end
            tests++;
            if ({got_addr, got_tick} !== {exp_addr, exp_tick}) begin
                fails++;
                $display("FAIL random addr(%0d,%0d): got addr=%h tick=%b exp addr=%h tick=%b",
                         h, v, got_addr, got_tick, exp_addr, exp_tick);
            end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        test_reset();
        test_sprite();
        test_clip();
        test_edges();
        test_key();
        test_latch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
